bob_queue: RTL
==============

Name: bob_queue

Overview:
- Parametrised in-order completion buffer with integrated storage: allocation pointer, retire pointer, occupancy counter and entry RAM in one block.
- Generalises the single-lane 63-entry allocator: arbitrary depth, up to ALLOC_MAX allocations and RET_MAX retirements per cycle, and partial squash on exception.
- Sits between the issue/allocate stage (tail) and the retire stage (head) in the control unit.

Parameters:
- DEPTH, 63, number of entries; any value 4..256, power of two not required.
- AW, 6, pointer width; must satisfy 2^AW >= DEPTH.
- WIDTH, 64, payload bits per entry.
- ALLOC_MAX, 2, maximum allocations per cycle (1..4).
- RET_MAX, 2, maximum retirements per cycle (1..4).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- except  in  1  squash request
- except_addr  in  AW  youngest surviving entry index when except=1
- except_all  in  1  with except: squash every entry and ignore except_addr
- new_en  in  1  allocation request
- new_cnt  in  clog2(ALLOC_MAX+1)  entries to allocate, 1..ALLOC_MAX
- new_data  in  ALLOC_MAX*WIDTH  payload, lane k in bits [k*WIDTH +: WIDTH]
- stall  in  1  downstream stall, blocks allocation
- new_addr  out  AW  index assigned to lane 0; lane k gets (new_addr+k) mod DEPTH
- doStall  out  1  free entries < ALLOC_MAX
- retire_cnt  in  clog2(RET_MAX+1)  entries retired this cycle
- retire_addr  out  AW  current head index (registered)
- retire_vld  out  RET_MAX  thermometer: bit k set when entry head+k is occupied
- retire_data  out  RET_MAX*WIDTH  payload of head+k, lane k
- count  out  AW+1  occupancy

Behaviour:
- Reset (rst=0, asynchronous): new_addr=0, retire_addr=0, count=0, retire_vld=0, doStall=0. RAM contents are not reset. Any in-flight allocate, retire or squash is discarded.
- All index arithmetic is modulo DEPTH: ptr+k >= DEPTH wraps to ptr+k-DEPTH.
- Allocation fires when new_en & !stall & !doStall. In that case:
  - lanes 0..new_cnt-1 write RAM at the following edge;
  - new_addr advances by new_cnt;
  - new_cnt=0 with new_en=1 is a no-op.
- doStall = (count > DEPTH-ALLOC_MAX). It is combinational from registered count and does not depend on this cycle's retire.
- Retire:
  - effective retire count r_eff = min(retire_cnt, count);
  - retire_addr advances by r_eff at the edge;
  - retire_vld and retire_data are combinational reads at the registered retire_addr and are valid in the same cycle.
- count update: count_next = count + a - r_eff, where a = allocated count. A simultaneous allocate and retire is legal; count never underflows or exceeds DEPTH.
- Write-to-retire latency: an entry written at edge T is visible on retire_data/retire_vld from cycle T+1.
- Squash has priority over allocate and retire in the same cycle; both are ignored.
  - except & except_all: new_addr <= retire_addr; count <= 0.
  - except & !except_all: new_addr <= (except_addr+1) mod DEPTH; count <= ((except_addr - retire_addr) mod DEPTH) + 1.
  - If count was 0, except without except_all is illegal (covered by a sim assertion) and behaves as except_all.
- Full: count=DEPTH means new_addr==retire_addr. Empty: count=0. Pointer equality alone is never used to decide full or empty.

Optional Feature:
- Macro: BOB_QUEUE_PARITY_EN.
- When defined:
  - each entry stores one extra even-parity bit computed from its lane's new_data at write;
  - a new output port parity_err [RET_MAX] is added; bit k is high when retire_vld[k]=1 and the recomputed parity of retire_data lane k mismatches the stored bit;
  - a bench-only force hook on the stored bit may be used to inject errors.
- When undefined: no parity storage, no parity_err port, RAM width is exactly WIDTH.

Test Plan:
- Reset mid-traffic: fill 10 entries, assert rst=0 for 1 cycle -> new_addr=0, retire_addr=0, count=0, retire_vld=0 immediately (asynchronous).
- Fill to full, DEPTH=63, ALLOC_MAX=2: allocate 2/cycle from empty -> doStall=1 once count=62; a single allocation with new_cnt=1 is blocked. Retire 2 -> count=60, doStall drops; allocation resumes.
- Wrap-around: retire_addr=61, new_addr=61, allocate 2 then 2 -> lane indices 61, 62, 0, 1; new_addr=2; retire 4 over two cycles -> retire_addr=2, data matches in order.
- Simultaneous: count=5; allocate 2 and retire_cnt=2 in one cycle -> count stays 5, both pointers advance by 2. retire_cnt=2 with count=1 -> r_eff=1, count=0.
- Partial squash: retire_addr=60, 8 entries (60..4); except=1, except_addr=1, with allocate and retire also asserted -> new_addr=2, count=5, retire_addr unchanged at 60.
- Full squash with parity build: except_all -> count=0, new_addr=retire_addr. Separately, with BOB_QUEUE_PARITY_EN, flip the stored parity of entry 3 -> parity_err[0]=1 exactly when head=3.

Source files
------------

// File: rtl/bob_queue_if.sv
// bob_queue_if: allocate / retire / squash bundle for the bob_queue completion buffer.
// The optional parity_err output exists only when BOB_QUEUE_PARITY_EN is defined.
interface bob_queue_if #(
  parameter int AW        = 6,
  parameter int WIDTH     = 64,
  parameter int ALLOC_MAX = 2,
  parameter int RET_MAX   = 2
);
  localparam int CW = $clog2(ALLOC_MAX + 1);
  localparam int RW = $clog2(RET_MAX + 1);

  logic                       except;
  logic [AW-1:0]              except_addr;
  logic                       except_all;
  logic                       new_en;
  logic [CW-1:0]              new_cnt;
  logic [ALLOC_MAX*WIDTH-1:0] new_data;
  logic                       stall;
  logic [AW-1:0]              new_addr;
  logic                       doStall;
  logic [RW-1:0]              retire_cnt;
  logic [AW-1:0]              retire_addr;
  logic [RET_MAX-1:0]         retire_vld;
  logic [RET_MAX*WIDTH-1:0]   retire_data;
  logic [AW:0]                count;
`ifdef BOB_QUEUE_PARITY_EN
  logic [RET_MAX-1:0]         parity_err;
`endif

  modport master (
    output except, except_addr, except_all, new_en, new_cnt, new_data, stall, retire_cnt,
`ifdef BOB_QUEUE_PARITY_EN
    input  parity_err,
`endif
    input  new_addr, doStall, retire_addr, retire_vld, retire_data, count
  );

  modport slave (
    input  except, except_addr, except_all, new_en, new_cnt, new_data, stall, retire_cnt,
`ifdef BOB_QUEUE_PARITY_EN
    output parity_err,
`endif
    output new_addr, doStall, retire_addr, retire_vld, retire_data, count
  );
endinterface

// File: rtl/bob_queue.sv
// bob_queue: in-order completion buffer. Tail pointer (new_addr) allocates up to
// ALLOC_MAX entries per cycle, head pointer (retire_addr) retires up to retire_cnt,
// an occupancy counter decides full/empty, and squash rewinds the tail.
// Optional feature macro: BOB_QUEUE_PARITY_EN adds a per-entry even-parity bit and
// the parity_err output.
module bob_queue #(
  parameter int DEPTH     = 63,
  parameter int AW        = 6,
  parameter int WIDTH     = 64,
  parameter int ALLOC_MAX = 2,
  parameter int RET_MAX   = 2
) (
  input  logic    clk,
  input  logic    rst,
  bob_queue_if.slave bus
);
`ifdef BOB_QUEUE_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif
  localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW:0] STALL_TH = (AW+1)'(DEPTH - ALLOC_MAX);
  localparam logic [AW:0] AMAX_W   = (AW+1)'(ALLOC_MAX);

  // (ptr + inc) mod DEPTH; inc never exceeds DEPTH so one subtraction suffices.
  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] ptr, input logic [AW:0] inc);
    logic [AW+1:0] sum;
    sum = {2'b00, ptr} + {1'b0, inc};
    if (sum >= {1'b0, DEPTH_W}) sum = sum - {1'b0, DEPTH_W};
    return sum[AW-1:0];
  endfunction

  // (to - from) mod DEPTH
  function automatic logic [AW:0] wrap_dist(input logic [AW-1:0] from, input logic [AW-1:0] to);
    if (to >= from) return {1'b0, to} - {1'b0, from};
    return {1'b0, to} + DEPTH_W - {1'b0, from};
  endfunction

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [MW-1:0] mem_q [DEPTH];
  logic [MW-1:0] entry_in [ALLOC_MAX];
  logic [MW-1:0] rd_word [RET_MAX];
  logic          stall_full;
  logic          alloc_fire;
  logic [AW:0]   alloc_n;
  logic [AW:0]   ret_req;
  logic [AW:0]   ret_n;

  // Backpressure looks only at the registered count, never at this cycle's retire.
  assign stall_full      = count_q > STALL_TH;
  assign bus.doStall     = stall_full;
  assign bus.new_addr    = wr_ptr_q;
  assign bus.retire_addr = rd_ptr_q;
  assign bus.count       = count_q;

  // Next-state pointers and occupancy; squash overrides allocate and retire.
  always_comb begin
    alloc_fire = bus.new_en && !bus.stall && !stall_full && !bus.except;
    alloc_n    = '0;
    ret_n      = '0;
    ret_req    = (AW+1)'(bus.retire_cnt);
    if (alloc_fire) begin
      alloc_n = (AW+1)'(bus.new_cnt);
      if (alloc_n > AMAX_W) alloc_n = AMAX_W;
    end
    if (!bus.except) ret_n = (ret_req < count_q) ? ret_req : count_q;
    wr_ptr_d = wrap_add(wr_ptr_q, alloc_n);
    rd_ptr_d = wrap_add(rd_ptr_q, ret_n);
    count_d  = count_q + alloc_n - ret_n;
    if (bus.except) begin
      rd_ptr_d = rd_ptr_q;
      // A partial squash of an empty queue has no survivor to keep: treat as squash-all.
      if (bus.except_all || count_q == '0) begin
        wr_ptr_d = rd_ptr_q;
        count_d  = '0;
      end else begin
        wr_ptr_d = wrap_add(bus.except_addr, (AW+1)'(1));
        count_d  = wrap_dist(rd_ptr_q, bus.except_addr) + (AW+1)'(1);
      end
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Build the stored word per allocation lane (payload plus optional parity).
  always_comb begin
    for (int k = 0; k < ALLOC_MAX; k++) begin
`ifdef BOB_QUEUE_PARITY_EN
      entry_in[k] = {^bus.new_data[k*WIDTH +: WIDTH], bus.new_data[k*WIDTH +: WIDTH]};
`else
      entry_in[k] = bus.new_data[k*WIDTH +: WIDTH];
`endif
    end
  end

  // ---- write stage: entry RAM, not reset; writes suppressed while in reset ----
  always_ff @(posedge clk) begin
    for (int k = 0; k < ALLOC_MAX; k++) begin
      if (rst && alloc_fire && ((AW+1)'(k) < alloc_n))
        mem_q[wrap_add(wr_ptr_q, (AW+1)'(k))] <= entry_in[k];
    end
  end

  // ---- read stage: combinational head window at the registered retire pointer ----
  always_comb begin
    bus.retire_data = '0;
    bus.retire_vld  = '0;
`ifdef BOB_QUEUE_PARITY_EN
    bus.parity_err  = '0;
`endif
    for (int k = 0; k < RET_MAX; k++) begin
      rd_word[k] = mem_q[wrap_add(rd_ptr_q, (AW+1)'(k))];
      bus.retire_data[k*WIDTH +: WIDTH] = rd_word[k][WIDTH-1:0];
      bus.retire_vld[k] = count_q > (AW+1)'(k);
`ifdef BOB_QUEUE_PARITY_EN
      bus.parity_err[k] = bus.retire_vld[k] && ((^rd_word[k][WIDTH-1:0]) != rd_word[k][WIDTH]);
`endif
    end
  end

  // A partial squash needs at least one live entry to name as the survivor.
  assert property (@(posedge clk) disable iff (!rst)
    !(bus.except && !bus.except_all && count_q == '0));
endmodule
